// File: rtl/mode_sched_pkg.sv
// Shared types and constants for the display mode scheduler.
package mode_sched_pkg;

  localparam int IDX_W     = 3;
  localparam int MAX_MODES = 8;

  localparam logic [7:0] MODE_TABLE [0:MAX_MODES-1] = '{
    8'h00, 8'h01, 8'h02, 8'h03, 8'h10, 8'h11, 8'h20, 8'h21
  };

  typedef enum logic {
    S_RUN  = 1'b0,
    S_HOLD = 1'b1
  } state_e;

  // Next table index, wrapping after the last used entry.
  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx,
                                                input int num_modes);
    if (int'(idx) >= num_modes - 1) return '0;
    return idx + 1'b1;
  endfunction

endpackage

// File: rtl/mode_scheduler_btn_debounce.sv
// Button conditioning: 2-FF synchronizer, counting debouncer and a
// one-cycle press event on each debounced rising edge. Release is silent.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 65536
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic press_o
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic [1:0]       sync_q;
  logic             level_q, level_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_q;

  // Count consecutive samples that disagree with the debounced level;
  // flip the level on the last one of the run.
  always_comb begin
    level_d = level_q;
    cnt_d   = cnt_q;
    if (sync_q[1] == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      level_d = ~level_q;
      cnt_d   = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Synchronizer, debounce state and registered press pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      level_q <= 1'b0;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], btn_i};
      level_q <= level_d;
      cnt_q   <= cnt_d;
      press_q <= level_d & ~level_q;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/mode_scheduler.sv
// Display mode sequencer for the VGA controller. Auto-advances through
// the mode table every FRAMES_PER_MODE frames, accepts next/hold buttons
// and jump requests, and only ever changes the mode at vblank start.
module mode_scheduler
  import mode_sched_pkg::*;
#(
  parameter int FRAMES_PER_MODE = 120,
  parameter int NUM_MODES       = 8,
  parameter int DEBOUNCE_CYCLES = 65536
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             vblank,
  input  logic             btn_next,
  input  logic             btn_hold,
  input  logic             jump_valid,
  input  logic [IDX_W-1:0] jump_idx,
  output logic [7:0]       mode_out,
  output logic [IDX_W-1:0] mode_idx,
  output logic             frame_tick,
  output logic             holding,
  output logic             pending
);

  localparam int FC_W = $clog2(FRAMES_PER_MODE + 1);
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(FRAMES_PER_MODE - 1);

  logic             next_press, hold_press;
  logic             vblank_q, frame_tick_q;
  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [FC_W-1:0]  frame_cnt_q, frame_cnt_d;
  logic             pend_step_q, pend_step_d;
  logic             pend_jump_q, pend_jump_d;
  logic [IDX_W-1:0] jump_tgt_q, jump_tgt_d;
  logic [7:0]       mode_out_q;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_next (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_i   (btn_next),
    .press_o (next_press)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_hold (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_i   (btn_hold),
    .press_o (hold_press)
  );

  // Vblank rising-edge detector producing the registered frame tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vblank_q     <= 1'b0;
      frame_tick_q <= 1'b0;
    end else begin
      vblank_q     <= vblank;
      frame_tick_q <= vblank & ~vblank_q;
    end
  end

  // Next-state: RUN/HOLD toggle, per-frame decision, request queuing.
  // The frame decision uses only requests already queued, so events
  // arriving in the tick cycle are held over to the following frame.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    frame_cnt_d = frame_cnt_q;
    pend_step_d = pend_step_q;
    pend_jump_d = pend_jump_q;
    jump_tgt_d  = jump_tgt_q;

    if (hold_press) begin
      state_d = (state_q == S_RUN) ? S_HOLD : S_RUN;
    end

    if (frame_tick_q) begin
      if (pend_jump_q) begin
        idx_d       = (int'(jump_tgt_q) >= NUM_MODES) ? '0 : jump_tgt_q;
        frame_cnt_d = '0;
        pend_jump_d = 1'b0;
        pend_step_d = 1'b0;
      end else if (pend_step_q) begin
        idx_d       = next_idx(idx_q, NUM_MODES);
        frame_cnt_d = '0;
        pend_step_d = 1'b0;
      end else if (state_q == S_RUN) begin
        if (frame_cnt_q == FC_LAST) begin
          idx_d       = next_idx(idx_q, NUM_MODES);
          frame_cnt_d = '0;
        end else begin
          frame_cnt_d = frame_cnt_q + 1'b1;
        end
      end
    end

    if (next_press) begin
      pend_step_d = 1'b1;
    end
    if (jump_valid) begin
      pend_jump_d = 1'b1;
      jump_tgt_d  = jump_idx;
    end
  end

  // Scheduler state registers; mode byte follows the new index directly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_RUN;
      idx_q       <= '0;
      frame_cnt_q <= '0;
      pend_step_q <= 1'b0;
      pend_jump_q <= 1'b0;
      jump_tgt_q  <= '0;
      mode_out_q  <= MODE_TABLE[0];
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      frame_cnt_q <= frame_cnt_d;
      pend_step_q <= pend_step_d;
      pend_jump_q <= pend_jump_d;
      jump_tgt_q  <= jump_tgt_d;
      mode_out_q  <= MODE_TABLE[idx_d];
    end
  end

  assign mode_out   = mode_out_q;
  assign mode_idx   = idx_q;
  assign frame_tick = frame_tick_q;
  assign holding    = (state_q == S_HOLD);
  assign pending    = pend_step_q | pend_jump_q;

endmodule

// File: tb/tb_mode_scheduler.sv
// Bench for mode_scheduler: two instances (8 and 6 modes) share all inputs
// and are compared frame by frame against a per-frame behavioural model.
module tb_mode_scheduler;

  localparam int FPM = 3;
  localparam int DEB = 4;

  localparam logic [7:0] TBL [8] = '{8'h00, 8'h01, 8'h02, 8'h03,
                                     8'h10, 8'h11, 8'h20, 8'h21};

  // act bits: 0 next press, 1 hold press, 2 jump, 3 short glitch, 4 reset
  localparam int A_NEXT = 1, A_HOLD = 2, A_JUMP = 4, A_GLITCH = 8, A_RST = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       vblank = 1'b0;
  logic       btn_next = 1'b0;
  logic       btn_hold = 1'b0;
  logic       jump_valid = 1'b0;
  logic [2:0] jump_idx = 3'd0;

  logic [7:0] mode_out_a, mode_out_b;
  logic [2:0] mode_idx_a, mode_idx_b;
  logic       tick_a, tick_b, hold_a, hold_b, pend_a, pend_b;

  int n_vec = 0;
  int n_err = 0;

  int m_idx [2];
  int m_cnt [2];
  int nm    [2] = '{8, 6};
  bit m_step, m_jump, m_hold;
  int m_tgt;

  mode_scheduler #(.FRAMES_PER_MODE(FPM), .NUM_MODES(8), .DEBOUNCE_CYCLES(DEB)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .vblank(vblank), .btn_next(btn_next), .btn_hold(btn_hold),
    .jump_valid(jump_valid), .jump_idx(jump_idx), .mode_out(mode_out_a), .mode_idx(mode_idx_a),
    .frame_tick(tick_a), .holding(hold_a), .pending(pend_a)
  );

  mode_scheduler #(.FRAMES_PER_MODE(FPM), .NUM_MODES(6), .DEBOUNCE_CYCLES(DEB)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .vblank(vblank), .btn_next(btn_next), .btn_hold(btn_hold),
    .jump_valid(jump_valid), .jump_idx(jump_idx), .mode_out(mode_out_b), .mode_idx(mode_idx_b),
    .frame_tick(tick_b), .holding(hold_b), .pending(pend_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_idx[k] = 0;
      m_cnt[k] = 0;
    end
    m_step = 0;
    m_jump = 0;
    m_hold = 0;
    m_tgt  = 0;
  endtask

  // What happens to each instance at the start of a vblank.
  task automatic model_frame();
    for (int k = 0; k < 2; k++) begin
      if (m_jump) begin
        m_idx[k] = (m_tgt >= nm[k]) ? 0 : m_tgt;
        m_cnt[k] = 0;
      end else if (m_step) begin
        m_idx[k] = (m_idx[k] + 1) % nm[k];
        m_cnt[k] = 0;
      end else if (!m_hold) begin
        m_cnt[k] = m_cnt[k] + 1;
        if (m_cnt[k] == FPM) begin
          m_idx[k] = (m_idx[k] + 1) % nm[k];
          m_cnt[k] = 0;
        end
      end
    end
    m_step = 0;
    m_jump = 0;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, "_idx_a"}, mode_idx_a, m_idx[0]);
    chk({tag, "_out_a"}, mode_out_a, TBL[m_idx[0]]);
    chk({tag, "_idx_b"}, mode_idx_b, m_idx[1]);
    chk({tag, "_out_b"}, mode_out_b, TBL[m_idx[1]]);
  endtask

  task automatic check_reset_values();
    chk("rst_out_a", mode_out_a, 8'h00);
    chk("rst_idx_a", mode_idx_a, 0);
    chk("rst_tick_a", tick_a, 0);
    chk("rst_hold_a", hold_a, 0);
    chk("rst_pend_a", pend_a, 0);
    chk("rst_idx_b", mode_idx_b, 0);
  endtask

  // One 100-cycle frame: 10 cycles of vblank, actions at cycle 30.
  task automatic run_frame(input int act, input int ji);
    int ticks;
    ticks = 0;
    vblank = 1'b1;
    tick();
    ticks += int'(tick_a);
    check_outputs("pre");
    model_frame();
    tick();
    ticks += int'(tick_a);
    check_outputs("post");
    chk("post_pend", pend_a, 0);
    for (int c = 2; c < 10; c++) begin
      tick();
      ticks += int'(tick_a);
    end
    vblank = 1'b0;
    for (int c = 10; c < 100; c++) begin
      if (c == 30) begin
        if ((act & (A_NEXT | A_GLITCH)) != 0) btn_next = 1'b1;
        if ((act & A_HOLD) != 0) btn_hold = 1'b1;
        if ((act & A_JUMP) != 0) begin
          jump_valid = 1'b1;
          jump_idx   = 3'(ji);
        end
        if ((act & A_NEXT) != 0) m_step = 1;
        if ((act & A_HOLD) != 0) m_hold = !m_hold;
        if ((act & A_JUMP) != 0) begin
          m_jump = 1;
          m_tgt  = ji;
        end
      end
      if (c == 31) jump_valid = 1'b0;
      if (c == 33 && (act & A_GLITCH) != 0) btn_next = 1'b0;
      if (c == 36) begin
        btn_next = 1'b0;
        btn_hold = 1'b0;
      end
      if (c == 60) begin
        chk("mid_hold", hold_a, m_hold);
        chk("mid_pend", pend_a, (m_step || m_jump));
        chk("mid_out_a", mode_out_a, TBL[m_idx[0]]);
      end
      if (c == 70 && (act & A_RST) != 0) begin
        rst_n = 1'b0;
        #1;
        check_reset_values();
        model_reset();
      end
      if (c == 75) rst_n = 1'b1;
      tick();
      ticks += int'(tick_a);
    end
    chk("frame_ticks", ticks, 1);
  endtask

  initial begin
    int r;
    int acts [6] = '{0, A_NEXT, A_HOLD, A_JUMP, A_JUMP | A_NEXT, A_GLITCH};

    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check_reset_values();
    model_reset();
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (20) tick();
    check_reset_values();

    // Free-running auto advance through a full wrap of the 8-entry table.
    for (int f = 0; f < 24; f++) run_frame(0, 0);
    chk("wrap_idx_a", mode_idx_a, 0);

    // Next press, then a glitch that must not register.
    run_frame(A_NEXT, 0);
    run_frame(0, 0);
    run_frame(A_GLITCH, 0);
    run_frame(0, 0);

    // Hold, step while held, release and resume counting.
    run_frame(A_HOLD, 0);
    for (int f = 0; f < 10; f++) run_frame(0, 0);
    run_frame(A_NEXT, 0);
    run_frame(0, 0);
    run_frame(A_HOLD, 0);
    for (int f = 0; f < 4; f++) run_frame(0, 0);

    // Jump beats a simultaneous step; out-of-range jump on the 6-mode unit.
    run_frame(A_JUMP | A_NEXT, 5);
    run_frame(A_JUMP, 7);
    run_frame(0, 0);

    for (int f = 0; f < 30; f++) begin
      r = $urandom_range(0, 5);
      run_frame(acts[r], $urandom_range(0, 7));
    end

    // Reset with a queued step; nothing may be applied afterwards.
    run_frame(A_NEXT | A_RST, 0);
    for (int f = 0; f < 3; f++) run_frame(0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mode_scheduler.md
Name: mode_scheduler

Overview:
- Sequences the display mode fed to the VGA controller's 8-bit mode input (ui_in).
- Steps through a fixed table of modes automatically, every FRAMES_PER_MODE frames.
- Accepts a debounced "next" button, a debounced "hold" button and an external jump request.
- Mode changes apply only at the start of vertical blanking, so no frame ever shows a mid-frame mode switch.
- Sits between the top-level inputs and the controller, in the same clock domain.

Parameters:
- FRAMES_PER_MODE, 120: frames each mode is shown in RUN state; must be ≥1.
- NUM_MODES, 8: number of table entries used (1..8).
- DEBOUNCE_CYCLES, 65536: consecutive stable cycles required before a debounced button level changes.

Ports:
- clk, in, 1: pixel clock, shared with the controller.
- rst_n, in, 1: asynchronous active-low reset.
- vblank, in, 1: controller vblank, synchronous to clk.
- btn_next, in, 1: raw async button; a press requests the next mode.
- btn_hold, in, 1: raw async button; a press toggles RUN/HOLD.
- jump_valid, in, 1: synchronous one-cycle jump request.
- jump_idx, in, 3: target table index for the jump.
- mode_out, out, 8: registered mode byte to the controller's ui_in.
- mode_idx, out, 3: current table index.
- frame_tick, out, 1: one-cycle pulse at each vblank rising edge.
- holding, out, 1: 1 when the FSM is in HOLD.
- pending, out, 1: a step or jump is queued for the next vblank.

Behaviour:
- Reset (async assert, sync-release use): mode_idx=0, mode_out=MODE_TABLE[0], state RUN, frame_cnt=0, pending=0, frame_tick=0, holding=0; all sync and debounce flops=0.
- Edge detect: vblank_q registers vblank. frame_tick is registered and goes high the cycle after vblank=1 is sampled with vblank_q=0. It lasts exactly one cycle.
- Buttons:
  - Each button passes a 2-FF synchronizer, then a debouncer. The debounced level flips only after DEBOUNCE_CYCLES consecutive samples differ from it.
  - A debounced 0→1 transition gives a one-cycle press event. Release is ignored.
- FSM, two states:
  - RUN: hold_press → HOLD.
  - HOLD: hold_press → RUN.
  - frame_cnt is not reset by a state change.
- Queuing:
  - next_press sets pending_step.
  - jump_valid sets pending_jump and latches jump_idx into jump_tgt; a later jump overwrites jump_tgt.
  - pending = pending_step | pending_jump.
  - Jump or press events in the same cycle as frame_tick are queued for the next frame, not applied now.
- Decision, on the edge where frame_tick is asserted:
  - pending_jump: idx←jump_tgt (if jump_tgt ≥ NUM_MODES, then idx←0), frame_cnt←0, clear both pendings. A jump beats a step.
  - else pending_step: idx←(idx+1) mod NUM_MODES, frame_cnt←0, clear pending_step. Applies in HOLD too.
  - else RUN and frame_cnt==FRAMES_PER_MODE-1: idx advances with wrap, frame_cnt←0.
  - else RUN: frame_cnt++.
  - else HOLD: frame_cnt unchanged.
- Output timing: mode_out←MODE_TABLE[new idx] one cycle after frame_tick. Latency from vblank rise to mode_out change is 2 clk cycles, which is well inside blanking.
- Widths:
  - frame_cnt is $clog2(FRAMES_PER_MODE+1) bits and never exceeds FRAMES_PER_MODE-1.
  - The debounce counter is $clog2(DEBOUNCE_CYCLES+1) bits and saturates.
- NUM_MODES=1: idx stays 0 and every advance is a no-op, but frame_cnt still resets.
- vblank held high for many cycles gives only one tick. vblank glitch-free by contract.
- Reset mid-frame or mid-debounce discards all queued requests.

Decomposition:
- Package mode_sched_pkg holds:
  - MODE_TABLE[0:7] = 8'h00, 8'h01, 8'h02, 8'h03, 8'h10, 8'h11, 8'h20, 8'h21.
  - The state enum {S_RUN, S_HOLD}.
  - Index width constant IDX_W=3.
- One sub-module, btn_debounce: synchronizer, debouncer and press-event output. Instantiated twice.

Test Plan (FRAMES_PER_MODE=3, NUM_MODES=8, DEBOUNCE_CYCLES=4, vblank pulse 10 cycles every 100):
- Reset release, no buttons: mode_out=8'h00. It becomes 8'h01 two cycles after the 3rd vblank rise, then 8'h02 after the 6th. frame_tick counts exactly one per vblank.
- Auto wrap: after 24 vblanks mode_idx=0 and mode_out=8'h00, having passed 8'h21 at idx 7.
- btn_next high 6 cycles mid-frame: pending=1 and mode_out is unchanged until the next vblank, then advances by one with frame_cnt=0. A 3-cycle glitch gives no event and pending stays 0.
- btn_hold press: holding=1; idx is unchanged across 10 vblanks. btn_next still steps idx by 1 at the next vblank. A second hold press returns to RUN, with counting resuming from the held frame_cnt.
- jump_valid with jump_idx=5 plus btn_next pending: at the next vblank idx=5, mode_out=8'h11, both pendings clear. jump_idx=7 with NUM_MODES=6 gives idx=0.
- rst_n asserted with pending=1 mid-frame: all outputs return to reset values immediately. After release no step occurs at the next vblank.
